// File: rtl/photodiode_rx.sv
// Photodiode-side 8N1 receiver: assembles PKT_LENGTH/8 back-to-back bytes into one packet,
// strobes new_data on a complete packet and frame_err on bad stop bits or inter-byte timeouts.
module photodiode_rx #(
  parameter int CLK_PER_BIT  = 54166,
  parameter int PKT_LENGTH   = 288,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [PKT_LENGTH-1:0] data,
  output logic                  new_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int NUM_BYTES = PKT_LENGTH / 8;
  localparam int GAP_MAX   = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int CNT_W     = $clog2(CLK_PER_BIT);
  localparam int GAP_W     = $clog2(GAP_MAX + 1);
  localparam int BYTE_W    = $clog2(NUM_BYTES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rs;
  logic [CNT_W-1:0]      bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift_byte;
  logic [PKT_LENGTH-1:0] pkt_sr;
  logic [BYTE_W-1:0]     byte_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  deliver;

  assign busy = (state != IDLE) || (byte_cnt != '0);

  // NOTE: every register here, including the packet shift register, is updated with
  // non-blocking assignments so all branches see the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rs         <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_byte <= '0;
      pkt_sr     <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      deliver    <= 1'b0;
      data       <= '0;
      new_data   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rs        <= rx_meta;
      new_data  <= 1'b0;
      frame_err <= 1'b0;

      // Final byte was accepted on the previous edge; publish the packet now.
      if (deliver) begin
        data     <= pkt_sr;
        new_data <= 1'b1;
        byte_cnt <= '0;
        deliver  <= 1'b0;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rs) begin
            state   <= START;
            gap_cnt <= '0;
          end else if (byte_cnt != '0 && !deliver) begin
            if (gap_cnt == GAP_LAST) begin
              frame_err <= 1'b1;
              byte_cnt  <= '0;
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end else begin
            gap_cnt <= '0;
          end
        end

        START: begin
          if (bit_cnt == CNT_MID) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= rs ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt    <= '0;
            shift_byte <= {rs, shift_byte[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (rs) begin
              pkt_sr   <= PKT_LENGTH'({pkt_sr, shift_byte});
              byte_cnt <= byte_cnt + BYTE_W'(1);
              deliver  <= (byte_cnt == BYTE_LAST);
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              byte_cnt  <= '0;
              state     <= WAIT_HI;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        WAIT_HI: begin
          // A held-low line must return high before a new start bit is accepted.
          bit_cnt <= '0;
          if (rs) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
